// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the Pong VGA raster sequencer:
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - counter width used by both raster axes
//   - update-window scheduler state encoding
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        WAIT_FRAME = 2'd2
    } upd_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// Modulo-N counter for one raster axis. Resets to N-1 so that the first
// enable after reset lands on 0.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   advance the counter this clock
//   cnt_nxt  out  value the counter takes at the next edge (combinational)
//   wrap     out  en high while at N-1, i.e. this edge wraps to 0
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int N = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_sequencer.sv
// ---------------------------------------------------------------------------
// vga_timing_sequencer
// Pong VGA raster sequencer: horizontal/vertical counters on the pixel
// strobe, registered sync/blank/coordinate decode, and a once-per-frame
// game-logic update window that only opens during vertical blanking.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   pix_en       in   pixel strobe, counters advance only when high
//   hsync/vsync  out  active-low syncs
//   video_on     out  raster inside the visible area
//   pix_x/pix_y  out  current coordinates (valid while video_on)
//   frame_start  out  one-clk pulse after entering (0,0)
//   upd_req      in   game logic wants an update window (level)
//   upd_grant    out  update window open
//   upd_done     in   one-clk pulse closing the window
//   upd_overrun  out  sticky: a window was force-closed at frame start
//
// Scheduler states:
//   state      | meaning
//   IDLE       | no window; may grant in vblank if not yet served this frame
//   GRANT      | window open until upd_done or raster re-enters (0,0)
//   WAIT_FRAME | this frame already served; wait for (0,0)
// ---------------------------------------------------------------------------
module vga_timing_sequencer
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    input  logic             upd_req,
    output logic             upd_grant,
    input  logic             upd_done,
    output logic             upd_overrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("H_TOTAL exceeds the 10-bit counter range");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("V_TOTAL exceeds the 10-bit counter range");
    end

    localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hcnt_nxt;
    logic [CNT_W-1:0] vcnt_nxt;
    logic             h_wrap;
    logic             v_wrap;
    logic             enter_origin;

    vga_axis_counter #(.N(H_TOTAL)) u_hcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_en),
        .cnt_nxt (hcnt_nxt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.N(V_TOTAL)) u_vcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_en & h_wrap),
        .cnt_nxt (vcnt_nxt),
        .wrap    (v_wrap)
    );

    // Vertical wrap already implies pix_en and horizontal wrap.
    assign enter_origin = v_wrap;

    // Decode from the next counter value so outputs line up with the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= enter_origin;
            if (pix_en) begin
                hsync    <= !((hcnt_nxt >= HS_START) && (hcnt_nxt <= HS_END));
                vsync    <= !((vcnt_nxt >= VS_START) && (vcnt_nxt <= VS_END));
                video_on <= (hcnt_nxt < H_ACT_L) && (vcnt_nxt < V_ACT_L);
                pix_x    <= hcnt_nxt;
                pix_y    <= vcnt_nxt;
            end
        end
    end

    upd_state_t state;
    upd_state_t state_nxt;
    logic       served;
    logic       served_nxt;
    logic       overrun_set;
    logic       win_ok;

    // Last line is excluded so a window can never straddle the frame start.
    assign win_ok = pix_en && (vcnt_nxt >= V_ACT_L) && (vcnt_nxt != V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            served      <= 1'b0;
            upd_grant   <= 1'b0;
            upd_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            served      <= served_nxt;
            upd_grant   <= (state_nxt == GRANT);
            upd_overrun <= upd_overrun | overrun_set;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enter_origin) begin
                    state_nxt = IDLE;
                end else if (served) begin
                    state_nxt = WAIT_FRAME;
                end else if (win_ok && upd_req) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (upd_done || enter_origin) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_FRAME: begin
                if (enter_origin) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        served_nxt  = served;
        overrun_set = 1'b0;
        if ((state == IDLE) && (state_nxt == GRANT)) begin
            served_nxt = 1'b1;
        end
        if (enter_origin) begin
            served_nxt = 1'b0;
        end
        // A simultaneous upd_done counts as a normal completion.
        if ((state == GRANT) && enter_origin && !upd_done) begin
            overrun_set = 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
module tb_vga_timing_sequencer;

    // Reduced raster so several full frames fit in a short run.
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       upd_req = 1'b0;
    logic       upd_done = 1'b0;
    logic       hsync, vsync, video_on, frame_start, upd_grant, upd_overrun;
    logic [9:0] pix_x, pix_y;

    always #5 clk = ~clk;

    vga_timing_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .upd_req     (upd_req),
        .upd_grant   (upd_grant),
        .upd_done    (upd_done),
        .upd_overrun (upd_overrun)
    );

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q[$];
    localparam logic [25:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0};

    // Reference model: raster position as a flat pixel index within the frame,
    // frames numbered, and the grant bookkeeping kept per frame number.
    int m_p;
    int m_frame;
    int m_grant_frame;
    bit m_started;
    bit m_grant;
    bit m_over;
    int m_grants = 0;
    int dut_grants = 0;
    logic prev_grant = 1'b0;

    function automatic logic [25:0] observed();
        return {hsync, vsync, video_on, pix_x, pix_y, frame_start, upd_grant, upd_overrun};
    endfunction

    task automatic model_reset();
        m_p           = FT - 1;
        m_frame       = 0;
        m_grant_frame = -1;
        m_started     = 0;
        m_grant       = 0;
        m_over        = 0;
    endtask

    task automatic model_step(bit pe, bit req, bit done);
        int  pn, h, v, ln;
        bit  ent, hs_e, vs_e, von_e;
        logic [9:0] x_e, y_e;
        pn  = pe ? (m_p + 1) % FT : m_p;
        ent = pe && (pn == 0);
        ln  = pn / HT;
        if (m_grant) begin
            if (done) begin
                m_grant = 0;
            end else if (ent) begin
                m_grant = 0;
                m_over  = 1;
            end
        end else if (pe && req && ln >= VA && ln != VT - 1 && m_grant_frame != m_frame) begin
            m_grant       = 1;
            m_grant_frame = m_frame;
            m_grants++;
        end
        if (ent) m_frame++;
        if (pe) m_started = 1;
        m_p = pn;
        h = pn % HT;
        v = pn / HT;
        hs_e  = !(h >= HA + HF && h < HA + HF + HS);
        vs_e  = !(v >= VA + VF && v < VA + VF + VS);
        von_e = (h < HA) && (v < VA);
        x_e   = m_started ? 10'(h) : 10'd0;
        y_e   = m_started ? 10'(v) : 10'd0;
        exp_q.push_back({hs_e, vs_e, von_e, x_e, y_e, ent, m_grant, m_over});
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(bit pe, bit req, bit done);
        pix_en   = pe;
        upd_req  = req;
        upd_done = done;
        @(posedge clk);
        model_step(pe, req, done);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [25:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = observed();
            checks++;
            if (a !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
            end
        end
        if (upd_grant && !prev_grant) dut_grants++;
        prev_grant = upd_grant;
    end

    // pm: 0 every 4th clk, 1 random, 2 every clk
    // rm: 0 low, 1 high, 2 high from line VA+3, 3 rises on last line and stays, 4 random
    // dm: 0 never, 1 pulse on line VA+2 while granted, 2 on the (0,0) entry edge, 3 random
    task automatic run(int n, int pm, int rm, int dm);
        bit latched = 0;
        for (int i = 0; i < n; i++) begin
            bit pe, req, done;
            int pn, vc;
            case (pm)
                0:       pe = (i % 4 == 0);
                1:       pe = ($urandom_range(0, 2) == 0);
                default: pe = 1'b1;
            endcase
            pn = pe ? (m_p + 1) % FT : m_p;
            vc = m_p / HT;
            if (rm == 3 && vc == VT - 1) latched = 1;
            case (rm)
                0:       req = 1'b0;
                1:       req = 1'b1;
                2:       req = (vc >= VA + 3);
                3:       req = latched;
                default: req = ($urandom_range(0, 3) != 0);
            endcase
            case (dm)
                0:       done = 1'b0;
                1:       done = m_grant && (vc == VA + 2);
                2:       done = pe && (pn == 0);
                default: done = ($urandom_range(0, 39) == 0);
            endcase
            cycle(pe, req, done);
        end
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== RESET_VEC) begin
            errors++;
            $display("FAIL async_reset actual=%h required=%h", observed(), RESET_VEC);
        end
        model_reset();
        pix_en   = 1'b0;
        upd_req  = 1'b0;
        upd_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_overrun(logic req_v, string name);
        checks++;
        if (upd_overrun !== req_v) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, upd_overrun, req_v);
        end
    endtask

    initial begin
        bit hit;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (observed() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values actual=%h required=%h", observed(), RESET_VEC);
        end
        rst_n = 1'b1;

        // Raster only, strobe every 4th clk, stray upd_done while idle.
        run(FT * 4 + 8, 0, 0, 3);
        // Request held high, done mid-vblank, random strobe.
        run(FT * 3 * 2, 1, 1, 1);
        // Request rising late in vblank.
        run(FT * 2, 2, 2, 1);
        // Request rising on the last line: next frame's vblank gets the grant.
        run(FT * 2 + 4, 2, 3, 1);

        // Never finishing: forced close sets the sticky overrun.
        async_reset();
        run(FT + FT / 2, 2, 1, 0);
        check_overrun(1'b1, "overrun_forced");
        run(FT / 2, 2, 0, 0);
        check_overrun(1'b1, "overrun_sticky");

        // Done on the same edge as the forced close: normal completion.
        async_reset();
        run(FT * 2 + 4, 2, 1, 2);
        check_overrun(1'b0, "overrun_done_at_wrap");

        // Reset while the window is open, then restart.
        async_reset();
        hit = 0;
        for (int i = 0; i < FT * 8 && !hit; i++) begin
            if (m_grant && (m_p / HT) == VA + 1) hit = 1;
            else run(1, 0, 1, 0);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_grant_wait actual=timeout required=grant_on_line_%0d", VA + 1);
        end
        async_reset();
        run(FT * 2 * 4, 0, 4, 3);

        checks++;
        if (dut_grants != m_grants) begin
            errors++;
            $display("FAIL grant_count actual=%0d required=%0d", dut_grants, m_grants);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_sequencer.md
# vga_timing_sequencer

Sequences the Pong VGA raster: free-running horizontal and vertical counters advanced by a pixel-rate enable. Decodes them into registered sync, blanking and pixel-coordinate outputs. Schedules a once-per-frame update window during vertical blanking, so game logic changes paddle/ball state only while nothing is drawn. Sits between the pixel-clock enable source and the renderer/game-logic blocks.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-clk pixel strobe; counters advance only when high
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high while (hcnt < H_ACTIVE) and (vcnt < V_ACTIVE)
- pix_x  out  10  current column; meaningful only when video_on
- pix_y  out  10  current line; meaningful only when video_on
- frame_start  out  1  one-clk pulse when raster enters (0,0)
- upd_req  in  1  game logic requests an update window (level)
- upd_grant  out  1  update window open
- upd_done  in  1  one-clk pulse: game logic finished its update
- upd_overrun  out  1  sticky: a window was force-closed before upd_done

## Operation
- hcnt counts 0..H_TOTAL-1 on pix_en and wraps to 0. vcnt advances on pix_en only when hcnt wraps, counting 0..V_TOTAL-1 and wrapping to 0.
- Reset: hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, so the first pix_en after release enters (0,0).
- Output reset values: hsync=1, vsync=1, video_on=0, pix_x=0, pix_y=0, frame_start=0, upd_grant=0, upd_overrun=0.
- Sync decode:
  - hsync=0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 at defaults.
  - vsync=0 for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491 at defaults.
- Update scheduler, 3-state FSM:
  - IDLE -> GRANT: on a pix_en edge with vcnt >= V_ACTIVE, vcnt != V_TOTAL-1, upd_req=1, and served=0. On that edge set served=1.
  - GRANT -> IDLE: on upd_done=1, or forced on the edge the raster enters (0,0).
  - Forced close without upd_done on the same edge: set upd_overrun.
  - IDLE also moves to WAIT_FRAME once served=1. WAIT_FRAME -> IDLE at frame_start, where served is cleared.
- Result: at most one grant per frame. The window never overlaps active video.
- Once granted, the window stays open if upd_req drops. Close it only via upd_done or the forced close.
- upd_done while upd_grant=0 is ignored.
- Simultaneous upd_done and forced close: treat as a normal completion; upd_overrun is not set.
- upd_overrun clears only on reset.
- rst_n asserted mid-frame or mid-grant: all state returns to reset values immediately (asynchronous). The first frame_start follows the first pix_en after release.

## Timing
- All outputs are registered and computed from the next counter value. They change on the same clk edge as the counters, with zero skew between pix_x/pix_y and hsync/vsync/video_on.
- frame_start is high for exactly one clk: the cycle after the pix_en edge that enters (0,0).
- upd_grant rises on the qualifying pix_en edge. It falls on the clk edge after upd_done is sampled high (1-clk latency), or on the (0,0) entry edge.
- Without pix_en, no output changes, except upd_grant falling on upd_done.
- Arithmetic: 10-bit unsigned counters. Elaboration error if H_TOTAL > 1024 or V_TOTAL > 1024.

## Structure
- Package vga_timing_pkg holds:
  - the default 640x480@60 timing constants;
  - the derived H_TOTAL/V_TOTAL;
  - the scheduler state enum (IDLE, GRANT, WAIT_FRAME).
- Sub-module vga_axis_counter: parameterised modulo-N counter with enable, wrap pulse, and reset-to-N-1. Instantiated twice: horizontal on pix_en, vertical on pix_en and horizontal wrap.
- Sync/blank decode and the scheduler FSM live in the top.

## Test plan
- Reset release, pix_en every 4th clk:
  - first pix_en gives frame_start pulse and (0,0) with video_on=1;
  - hsync low exactly 96 pixels starting at pix 656;
  - 800 pixels per line, 525 lines per frame.
- upd_req held high from reset:
  - upd_grant rises entering line 480 col 0;
  - upd_done at line 500 drops grant 1 clk later;
  - no second grant until the next frame's vblank.
- upd_req rising at line 510: grant on the next pix_en.
- upd_req rising during line 524: no grant this frame; grant at line 480 of the next frame.
- Granted, upd_done never sent: grant drops entering (0,0) and upd_overrun=1. Repeat with upd_done on that same edge: upd_overrun stays 0.
- rst_n pulsed low mid-grant at line 495: all outputs go to reset values asynchronously, and sequencing restarts cleanly.
- upd_done pulsed while idle: no state change.
